// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: data width, default FIFO depth
// and the width of the dropped-byte counter.
package uart_pkg;

  localparam int unsigned UART_DATA_W        = 8;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 16;
  localparam int unsigned DROP_CNT_W         = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x UART_DATA_W register array: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [UART_DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]      raddr_i,
  output logic [UART_DATA_W-1:0] rdata_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: pushes on the rising edge of rx_done, FWFT valid/ready read port,
// sticky overrun flag. Define UART_RX_FIFO_STATS_EN to build the saturating drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_done,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [ADDR_W:0]        count,
  output logic                   full,
  output logic                   overrun,
  input  logic                   clr_ovr,
  output logic [DROP_CNT_W-1:0]  drop_cnt
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);

  logic              rx_done_q;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, wr_en, drop;

  assign push     = rx_done & ~rx_done_q;
  assign full     = (count_q == FullCount);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  // When full, a simultaneous pop frees the slot the write lands in.
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d  = rd_ptr_q + ADDR_W'(pop);
    count_d   = count_q + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
    overrun_d = overrun_q;
    if (clr_ovr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_done_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign count   = count_q;
  assign overrun = overrun_q;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

`ifdef UART_RX_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_ovr) begin
      drop_cnt_d = drop ? DROP_CNT_W'(1) : '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table-driven vectors plus hand-written sequences,
// with a queue-based scoreboard that predicts occupancy, flags and output order.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_done;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [ADDR_W:0]  count;
  logic             full;
  logic             overrun;
  logic             clr_ovr;
  logic [7:0]       drop_cnt;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .full     (full),
    .overrun  (overrun),
    .clr_ovr  (clr_ovr),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard / reference model state
  bit [7:0] exp_q[$];
  bit       prev_done = 1'b0;
  bit       ovr_m     = 1'b0;
  int       drop_m    = 0;
  bit [7:0] last_pop  = 8'h00;

  typedef struct {
    logic       rst;
    logic       done;
    logic [7:0] data;
    logic       rdy;
    int         cnt;
    logic       vld;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int exp_drop();
`ifdef UART_RX_FIFO_STATS_EN
    return drop_m;
`else
    return 0;
`endif
  endfunction

  task automatic check_state();
    chk("count", int'(count), exp_q.size());
    chk("rd_valid", int'(rd_valid), int'(exp_q.size() > 0));
    chk("full", int'(full), int'(exp_q.size() == DEPTH));
    chk("overrun", int'(overrun), int'(ovr_m));
    chk("drop_cnt", int'(drop_cnt), exp_drop());
    if (exp_q.size() > 0) chk("rd_data_head", int'(rd_data), int'(exp_q[0]));
  endtask

  // Predict the effect of the current inputs at the next edge, then advance.
  task automatic step();
    bit push_m, pop_m, full_m, drop_e;
    if (rst) begin
      exp_q.delete();
      prev_done = 1'b0;
      ovr_m     = 1'b0;
      drop_m    = 0;
    end else begin
      push_m = rx_done && !prev_done;
      full_m = (exp_q.size() == DEPTH);
      pop_m  = rd_ready && (exp_q.size() > 0);
      drop_e = push_m && full_m && !pop_m;
      if (pop_m) begin
        chk("pop_data", int'(rd_data), int'(exp_q[0]));
        last_pop = exp_q.pop_front();
      end
      if (push_m && !drop_e) exp_q.push_back(rx_data);
      if (clr_ovr) ovr_m = 1'b0;
      if (drop_e)  ovr_m = 1'b1;
      if (clr_ovr) drop_m = drop_e ? 1 : 0;
      else if (drop_e && drop_m != 255) drop_m++;
      prev_done = rx_done;
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic push_byte(input bit [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rd_ready = 1'b0; clr_ovr = 1'b0;

    // Reset, then 0xA5 with rx_done held 5 cycles, then pop it.
    vecs[0] = '{rst:1, done:0, data:8'h00, rdy:0, cnt:0, vld:0, rdd:8'h00};
    vecs[1] = '{rst:0, done:1, data:8'hA5, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[2] = '{rst:0, done:1, data:8'h11, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[3] = '{rst:0, done:1, data:8'h22, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[4] = '{rst:0, done:1, data:8'h33, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[5] = '{rst:0, done:1, data:8'h44, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[6] = '{rst:0, done:0, data:8'h55, rdy:0, cnt:1, vld:1, rdd:8'hA5};
    vecs[7] = '{rst:0, done:0, data:8'h00, rdy:1, cnt:0, vld:0, rdd:8'h00};

    step();
    for (int i = 0; i < 8; i++) begin
      rst      = vecs[i].rst;
      rx_done  = vecs[i].done;
      rx_data  = vecs[i].data;
      rd_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].cnt);
      chk($sformatf("vec%0d_valid", i), int'(rd_valid), int'(vecs[i].vld));
      if (vecs[i].vld) chk($sformatf("vec%0d_data", i), int'(rd_data), int'(vecs[i].rdd));
    end
    rd_ready = 1'b0;

    // Fill to full, then drain in order.
    for (int i = 1; i <= DEPTH; i++) push_byte(8'(i));
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), DEPTH);
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    rd_ready = 1'b0;
    chk("drain_last", int'(last_pop), 8'h10);
    chk("drain_valid", int'(rd_valid), 0);

    // Overflow drop, clear, and drop coinciding with clear.
    for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
    push_byte(8'h77);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_count", int'(count), DEPTH);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", int'(overrun), 0);
    chk("drop_clr", int'(drop_cnt), 0);
    push_byte(8'h78);
    push_byte(8'h79);
    rx_data = 8'h7A; rx_done = 1'b1; clr_ovr = 1'b1;
    step();
    rx_done = 1'b0; clr_ovr = 1'b0;
    chk("ovr_set_wins", int'(overrun), 1);
    step();

    // Full with simultaneous push and pop: no overrun, new byte emerges last.
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    rx_data = 8'h55; rx_done = 1'b1; rd_ready = 1'b1;
    step();
    rx_done = 1'b0; rd_ready = 1'b0;
    chk("pp_full_count", int'(count), DEPTH);
    chk("pp_full_ovr", int'(overrun), 0);
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) step();
    rd_ready = 1'b0;
    chk("pp_last_55", int'(last_pop), 8'h55);

    // 40 bytes, pop after each push: pointers wrap, occupancy stays <= 1.
    for (int i = 0; i < 40; i++) begin
      rx_data = 8'(8'hC0 + i); rx_done = 1'b1; rd_ready = 1'b1;
      step();
      chk("wrap_le1_a", int'(count <= 1), 1);
      rx_done = 1'b0;
      step();
      chk("wrap_le1_b", int'(count <= 1), 1);
      chk("wrap_data", int'(last_pop), int'(8'(8'hC0 + i)));
    end
    rd_ready = 1'b0;

    // Reset mid-operation, with rx_done high across reset deassertion.
    for (int i = 0; i < 7; i++) push_byte(8'h90 + 8'(i));
    chk("pre_rst_count", int'(count), 7);
    rst = 1'b1; rx_done = 1'b1; rx_data = 8'hE1;
    step();
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovr", int'(overrun), 0);
    rst = 1'b0;
    step();
    chk("post_rst_push", int'(count), 1);
    chk("post_rst_data", int'(rd_data), 8'hE1);
    rx_done = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
